// File: rtl/audio_frame_fifo.sv
// Stereo frame FIFO between CPU audio register path and i2s_master (16 x {L,R} frames).
// Latency: frame pushed at edge k into an empty FIFO strobes out_write in the cycle after edge k+1.
// Backpressure: in_full drops writes and sets sticky overflow; out_full holds the drain FSM idle.
// Optional low-level interrupt output low_irq is built when AUDIO_FRAME_FIFO_IRQ_EN is defined.
module audio_frame_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int SAMPLE_WIDTH = 24
`ifdef AUDIO_FRAME_FIFO_IRQ_EN
    ,
    parameter int LOW_WATERMARK = 4
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [SAMPLE_WIDTH-1:0] in_l,
    input  logic [SAMPLE_WIDTH-1:0] in_r,
    input  logic                    in_valid,
    output logic                    in_full,
    output logic [SAMPLE_WIDTH-1:0] out_l,
    output logic [SAMPLE_WIDTH-1:0] out_r,
    output logic                    out_write,
    input  logic                    out_full,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    overflow
`ifdef AUDIO_FRAME_FIFO_IRQ_EN
    ,
    output logic                    low_irq
`endif
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int LVL_W   = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic [FRAME_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    in_full_q, in_full_d;
    logic                    overflow_q, overflow_d;
    state_t                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] out_l_q, out_l_d;
    logic [SAMPLE_WIDTH-1:0] out_r_q, out_r_d;
    logic                    out_write_q, out_write_d;
    logic                    push;
    logic                    pop;
    logic [FRAME_W-1:0]      rd_frame;

    // in_full is registered, so a write in the cycle the FIFO reads full is dropped
    // even if a frame drains on the same edge.
    assign push     = in_valid && !in_full_q && !flush;
    assign rd_frame = mem_q[rd_ptr_q];

    // Frame storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_l, in_r};
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state: issue, then a mandatory gap so i2s_master full can update.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if ((level_q != '0) && !out_full) state_d = S_ISSUE;
                S_ISSUE: state_d = S_GAP;
                S_GAP:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Drain FSM outputs: pop on the IDLE->ISSUE transition and load the output frame.
    always_comb begin
        pop         = (state_q == S_IDLE) && (state_d == S_ISSUE);
        out_write_d = pop;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        if (pop) begin
            {out_l_d, out_r_d} = rd_frame;
        end
    end

    // Pointer, level and flag next state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (in_valid && in_full_q) overflow_d = 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        in_full_d = (level_d == LVL_FULL);
    end

    // Registered pointers, level, flags and output frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_full_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_write_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_full_q   <= in_full_d;
            overflow_q  <= overflow_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_write_q <= out_write_d;
        end
    end

    // A flush landing in the ISSUE cycle must suppress the strobe already registered
    // for that cycle, so the strobe is the only output gated after the flop.
    assign out_write = out_write_q & ~flush;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign in_full   = in_full_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

`ifdef AUDIO_FRAME_FIFO_IRQ_EN
    logic low_irq_q;

    // Low-level indication samples the registered level, so it trails level by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_irq_q <= 1'b0;
        end else begin
            low_irq_q <= (level_q <= LVL_W'(LOW_WATERMARK));
        end
    end

    assign low_irq = low_irq_q;
`endif

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Scoreboard bench for audio_frame_fifo: stimulus pushes accepted frames into a queue,
// a negedge monitor pops and compares on every out_write strobe and checks level/flags.
// The model treats occupancy as frames accepted but not yet strobed.
module tb_audio_frame_fifo;

    localparam int DL2   = 4;
    localparam int SW    = 24;
    localparam int DEPTH = 16;
    localparam int LWM   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [SW-1:0] in_l, in_r;
    logic          in_valid;
    logic          in_full;
    logic [SW-1:0] out_l, out_r;
    logic          out_write;
    logic          out_full;
    logic [DL2:0]  level;
    logic          overflow;
`ifdef AUDIO_FRAME_FIFO_IRQ_EN
    logic          low_irq;
`endif

    audio_frame_fifo #(.DEPTH_LOG2(DL2), .SAMPLE_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .in_full(in_full),
        .out_l(out_l), .out_r(out_r), .out_write(out_write), .out_full(out_full),
        .level(level), .overflow(overflow)
`ifdef AUDIO_FRAME_FIFO_IRQ_EN
        , .low_irq(low_irq)
`endif
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [2*SW-1:0]  exp_q[$];
    logic [2*SW-1:0]  last_frame = '0;
    logic [2*SW-1:0]  f_m;
    bit               ovf_m = 1'b0;
    bit               mon_en = 1'b0;
    bit               prev_wr = 1'b0;
    bit               prev_ofull = 1'b0;
    int               cyc = 0;
    int               strobe_cyc[$];
    int               prev_lvl = 0;
    bit               irq_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares every strobe with the scoreboard head and checks status each cycle.
    always @(negedge clk) begin
        if (reset) begin
            irq_vld = 1'b0;
        end else if (mon_en) begin
            if (out_write) begin
                chk("no_back_to_back", prev_wr, 0);
                chk("strobe_only_after_not_full", prev_ofull, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got frame %0h expected none", {out_l, out_r});
                end else begin
                    f_m = exp_q.pop_front();
                    chk("frame_data", {out_l, out_r}, f_m);
                    last_frame = f_m;
                end
                strobe_cyc.push_back(cyc);
            end else begin
                chk("hold_data", {out_l, out_r}, last_frame);
            end
            chk("level", level, exp_q.size());
            chk("in_full", in_full, exp_q.size() == DEPTH);
            chk("overflow", overflow, ovf_m);
`ifdef AUDIO_FRAME_FIFO_IRQ_EN
            if (irq_vld) chk("low_irq", low_irq, prev_lvl <= LWM);
            prev_lvl = exp_q.size();
            irq_vld  = 1'b1;
`endif
            prev_wr    = out_write;
            prev_ofull = out_full;
        end
        cyc++;
    end

    // One clock of stimulus; the model accepts a frame only when occupancy is below depth.
    task automatic step(input bit v, input logic [SW-1:0] l, input logic [SW-1:0] r, input bit fl);
        if (fl && out_write) last_frame = exp_q.pop_front();
        in_valid = v;
        in_l     = l;
        in_r     = r;
        flush    = fl;
        if (fl) begin
            #1;
            chk("flush_gates_strobe", out_write, 0);
        end
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end else if (v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
            else ovf_m = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int  n0;
        bit  seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0; out_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_in_full", in_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_write", out_write, 0);
        chk("rst_out_l", out_l, 0);
        chk("rst_out_r", out_r, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single frame: latency and one-cycle strobe.
        step(1'b1, 24'h123456, 24'hABCDEF, 1'b0);
        chk("lat_level_1", level, 1);
        step(1'b0, '0, '0, 1'b0);
        chk("lat_strobe", out_write, 1);
        chk("lat_out_l", out_l, 24'h123456);
        chk("lat_out_r", out_r, 24'hABCDEF);
        chk("lat_level_0", level, 0);
        step(1'b0, '0, '0, 1'b0);
        chk("strobe_one_cycle", out_write, 0);
        idle(3);

        // Fill while out_full, overflow on the 17th, then drain at one frame per 3 cycles.
        out_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) step(1'b1, SW'(i), SW'(i), 1'b0);
        chk("fill_in_full", in_full, 1);
        chk("fill_level", level, 16);
        step(1'b1, 24'h00DEAD, 24'h00BEEF, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 16);
        n0 = strobe_cyc.size();
        out_full = 1'b0;
        for (int t = 0; t < 80 && (strobe_cyc.size() - n0) < DEPTH; t++) idle(1);
        chk("drain_count", strobe_cyc.size() - n0, 16);
        if (strobe_cyc.size() >= n0 + DEPTH)
            for (int k = 1; k < DEPTH; k++)
                chk("drain_spacing", strobe_cyc[n0+k] - strobe_cyc[n0+k-1], 3);
        idle(2);
        step(1'b0, '0, '0, 1'b1);
        chk("flush_clears_ovf", overflow, 0);

        // Continuous writes with free drain: wrap, drops and overflow.
        for (int i = 0; i < 40; i++) step(1'b1, SW'($urandom), SW'($urandom), 1'b0);
        chk("burst_ovf", overflow, 1);
        for (int t = 0; t < 80 && exp_q.size() != 0; t++) idle(1);
        idle(4);
        chk("burst_drained", level, 0);
        step(1'b0, '0, '0, 1'b1);

        // Push and pop on the same edge at level 5.
        out_full = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, SW'(24'h500 + i), SW'($urandom), 1'b0);
        idle(1);
        chk("pp_level_before", level, 5);
        out_full = 1'b0;
        step(1'b1, 24'h0005FF, 24'h0A0A0A, 1'b0);
        chk("pp_level_same", level, 5);
        chk("pp_strobe", out_write, 1);
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) idle(1);
        idle(4);

        // Flush landing in an ISSUE cycle.
        out_full = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, SW'(24'h600 + i), SW'(24'h660 + i), 1'b0);
        out_full = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            idle(1);
            seen = out_write;
        end
        chk("issue_reached", seen, 1);
        step(1'b0, '0, '0, 1'b1);
        chk("flush_level", level, 0);
        chk("flush_ovf", overflow, 0);
        step(1'b1, 24'h0F1E2D, 24'h3C4B5A, 1'b0);
        n0 = strobe_cyc.size();
        for (int t = 0; t < 10 && strobe_cyc.size() == n0; t++) idle(1);
        chk("post_flush_first", last_frame, {24'h0F1E2D, 24'h3C4B5A});
        idle(3);

        // Random mix of writes, backpressure and flushes.
        for (int i = 0; i < 300; i++) begin
            out_full = ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), SW'($urandom), SW'($urandom),
                 ($urandom_range(0, 29) == 0));
        end
        out_full = 1'b0;
        for (int t = 0; t < 80 && exp_q.size() != 0; t++) idle(1);
        idle(4);

        // Reset in the middle of an issue.
        out_full = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, SW'(24'h700 + i), SW'(24'h770 + i), 1'b0);
        out_full = 1'b0;
        idle(1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        ovf_m = 1'b0;
        last_frame = '0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_out_write", out_write, 0);
        chk("mid_rst_out_l", out_l, 0);
        chk("mid_rst_in_full", in_full, 0);
        @(posedge clk);
        #1;
        prev_wr = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, SW'($urandom), SW'($urandom), 1'b0);
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) idle(1);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
